// File: rtl/game_flow_sequencer.sv
// Bumpy top-level game-flow controller: sequences the menu, play, died,
// win and game-over screens, owns lives and level progression, and drives
// the level-datapath reset and screen-select code.
module game_flow_sequencer #(
  parameter int unsigned SCREEN_SEC  = 3,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned NUM_LEVELS  = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       one_sec,
  input  logic       start_req,
  input  logic [1:0] lvl_selected,
  input  logic       bumpy_died,
  input  logic       level_comp,
  output logic [2:0] game_state,
  output logic       reset_lvl_N,
  output logic [1:0] lvl,
  output logic [2:0] lives,
  output logic [3:0] secs_left
);

  typedef enum logic [2:0] {
    S_MENU = 3'd0,
    S_PLAY = 3'd1,
    S_DIED = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  localparam logic [1:0] LAST_LVL   = 2'(NUM_LEVELS - 1);
  localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
  localparam logic [3:0] SCR_LEN    = 4'(SCREEN_SEC);
  localparam logic [3:0] SCR_LAST   = 4'(SCREEN_SEC - 1);

  state_t     state_q, state_d;
  logic [1:0] lvl_q, lvl_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] timer_q, timer_d;
  logic       start_d_q, died_d_q, level_d_q;

  logic       evt_start, evt_died, evt_level;
  logic       timed;
  logic       tick_last;

  assign evt_start = start_req  & ~start_d_q;
  assign evt_died  = bumpy_died & ~died_d_q;
  assign evt_level = level_comp & ~level_d_q;

  assign timed     = (state_q == S_DIED) || (state_q == S_WIN) || (state_q == S_OVER);
  assign tick_last = one_sec && (timer_q == SCR_LAST);

  // State, counters and edge-detect registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= S_MENU;
      lvl_q     <= '0;
      lives_q   <= LIVES_INIT;
      timer_q   <= '0;
      start_d_q <= 1'b0;
      died_d_q  <= 1'b0;
      level_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      lives_q   <= lives_d;
      timer_q   <= timer_d;
      start_d_q <= start_req;
      died_d_q  <= bumpy_died;
      level_d_q <= level_comp;
    end
  end

  // Next-state, level/lives updates and screen timer
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    lives_d = lives_q;
    timer_d = timer_q;

    case (state_q)
      S_MENU: begin
        timer_d = '0;
        if (evt_start) begin
          lvl_d   = (lvl_selected > LAST_LVL) ? LAST_LVL : lvl_selected;
          lives_d = LIVES_INIT;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        timer_d = '0;
        if (evt_died) begin
          if (lives_q <= 3'd1) begin
            lives_d = '0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - 3'd1;
            state_d = S_DIED;
          end
        end else if (evt_level) begin
          state_d = S_WIN;
        end
      end
      S_DIED: begin
        if (one_sec) timer_d = timer_q + 4'd1;
        if (tick_last) state_d = S_PLAY;
      end
      S_WIN: begin
        if (one_sec) timer_d = timer_q + 4'd1;
        if (tick_last) begin
          if (lvl_q >= LAST_LVL) begin
            lvl_d   = '0;
            state_d = S_MENU;
          end else begin
            lvl_d   = lvl_q + 2'd1;
            state_d = S_PLAY;
          end
        end
      end
      S_OVER: begin
        if (one_sec) timer_d = timer_q + 4'd1;
        if (tick_last) begin
          lvl_d   = '0;
          lives_d = LIVES_INIT;
          state_d = S_MENU;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_MENU;
      end
    endcase

    // Timer restarts from zero on every state change, so a tick in the
    // entry cycle is never counted by the new screen.
    if (state_d != state_q) timer_d = '0;
  end

  // Output decode straight from registered state
  always_comb begin
    game_state  = state_q;
    reset_lvl_N = (state_q == S_PLAY);
    lvl         = lvl_q;
    lives       = lives_q;
    secs_left   = timed ? (SCR_LEN - timer_q) : '0;
  end

endmodule

// File: tb/tb_game_flow_sequencer.sv
module tb_game_flow_sequencer;

  logic       clk = 1'b0;
  logic       resetN;
  logic       one_sec;
  logic       start_req;
  logic [1:0] lvl_selected;
  logic       bumpy_died;
  logic       level_comp;
  logic [2:0] game_state;
  logic       reset_lvl_N;
  logic [1:0] lvl;
  logic [2:0] lives;
  logic [3:0] secs_left;

  int checks = 0;
  int failures = 0;

  game_flow_sequencer #(
    .SCREEN_SEC (3),
    .START_LIVES(3),
    .NUM_LEVELS (3)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .one_sec     (one_sec),
    .start_req   (start_req),
    .lvl_selected(lvl_selected),
    .bumpy_died  (bumpy_died),
    .level_comp  (level_comp),
    .game_state  (game_state),
    .reset_lvl_N (reset_lvl_N),
    .lvl         (lvl),
    .lives       (lives),
    .secs_left   (secs_left)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sec_pulse();
    one_sec = 1'b1;
    tick();
    one_sec = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; one_sec = 1'b0; start_req = 1'b0; lvl_selected = 2'd0;
    bumpy_died = 1'b0; level_comp = 1'b0;
    tick(); tick();
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (game_state !== 3'd0 || reset_lvl_N !== 1'b0 || lives !== 3'd3 ||
          lvl !== 2'd0 || secs_left !== 4'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got st=%0d rn=%0b lives=%0d lvl=%0d secs=%0d exp st=0 rn=0 lives=3 lvl=0 secs=0",
                 i, game_state, reset_lvl_N, lives, lvl, secs_left);
      end
    end
    // death/level events are ignored in the menu
    bumpy_died = 1'b1; level_comp = 1'b1;
    tick(); tick();
    checks++;
    if (game_state !== 3'd0 || lives !== 3'd3) begin
      failures++;
      $display("FAIL menu_ignore got st=%0d lives=%0d exp st=0 lives=3", game_state, lives);
    end
    bumpy_died = 1'b0; level_comp = 1'b0;
    tick();
  endtask

  task automatic test_start();
    lvl_selected = 2'd2; start_req = 1'b1;
    tick();
    checks++;
    if (game_state !== 3'd1 || lvl !== 2'd2 || lives !== 3'd3 || reset_lvl_N !== 1'b1) begin
      failures++;
      $display("FAIL start got st=%0d lvl=%0d lives=%0d rn=%0b exp st=1 lvl=2 lives=3 rn=1",
               game_state, lvl, lives, reset_lvl_N);
    end
    // a second start edge while playing does nothing
    start_req = 1'b0; tick();
    start_req = 1'b1; tick();
    start_req = 1'b0; tick();
    checks++;
    if (game_state !== 3'd1 || lvl !== 2'd2) begin
      failures++;
      $display("FAIL start_in_play got st=%0d lvl=%0d exp st=1 lvl=2", game_state, lvl);
    end
  endtask

  task automatic test_died_hold();
    logic [3:0] exp_secs [0:1];
    exp_secs[0] = 4'd2; exp_secs[1] = 4'd1;
    bumpy_died = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (game_state !== 3'd2 || lives !== 3'd2 || secs_left !== 4'd3 || reset_lvl_N !== 1'b0) begin
      failures++;
      $display("FAIL died_hold got st=%0d lives=%0d secs=%0d rn=%0b exp st=2 lives=2 secs=3 rn=0",
               game_state, lives, secs_left, reset_lvl_N);
    end
    for (int i = 0; i < 2; i++) begin
      sec_pulse(); tick();
      checks++;
      if (game_state !== 3'd2 || secs_left !== exp_secs[i]) begin
        failures++;
        $display("FAIL died_count n=%0d got st=%0d secs=%0d exp st=2 secs=%0d",
                 i, game_state, secs_left, exp_secs[i]);
      end
    end
    sec_pulse();
    checks++;
    if (game_state !== 3'd1 || reset_lvl_N !== 1'b1 || secs_left !== 4'd0 || lives !== 3'd2 || lvl !== 2'd2) begin
      failures++;
      $display("FAIL died_exit got st=%0d rn=%0b secs=%0d lives=%0d lvl=%0d exp st=1 rn=1 secs=0 lives=2 lvl=2",
               game_state, reset_lvl_N, secs_left, lives, lvl);
    end
    tick(); tick();
    checks++;
    if (game_state !== 3'd1 || lives !== 3'd2) begin
      failures++;
      $display("FAIL died_no_retrig got st=%0d lives=%0d exp st=1 lives=2", game_state, lives);
    end
    bumpy_died = 1'b0; tick();
  endtask

  task automatic test_died_and_level();
    // lose one more life to reach lives=1
    bumpy_died = 1'b1; tick(); bumpy_died = 1'b0;
    sec_pulse(); sec_pulse(); sec_pulse();
    checks++;
    if (game_state !== 3'd1 || lives !== 3'd1) begin
      failures++;
      $display("FAIL to_last_life got st=%0d lives=%0d exp st=1 lives=1", game_state, lives);
    end
    // death beats level-complete; entry-cycle one_sec is not counted
    bumpy_died = 1'b1; level_comp = 1'b1; one_sec = 1'b1;
    tick();
    one_sec = 1'b0; bumpy_died = 1'b0; level_comp = 1'b0;
    checks++;
    if (game_state !== 3'd4 || lives !== 3'd0 || secs_left !== 4'd3) begin
      failures++;
      $display("FAIL over_entry got st=%0d lives=%0d secs=%0d exp st=4 lives=0 secs=3",
               game_state, lives, secs_left);
    end
    sec_pulse(); sec_pulse();
    checks++;
    if (game_state !== 3'd4 || secs_left !== 4'd1) begin
      failures++;
      $display("FAIL over_count got st=%0d secs=%0d exp st=4 secs=1", game_state, secs_left);
    end
    sec_pulse();
    checks++;
    if (game_state !== 3'd0 || lives !== 3'd3 || lvl !== 2'd0 || secs_left !== 4'd0) begin
      failures++;
      $display("FAIL over_exit got st=%0d lives=%0d lvl=%0d secs=%0d exp st=0 lives=3 lvl=0 secs=0",
               game_state, lives, lvl, secs_left);
    end
  endtask

  task automatic test_win_progress();
    lvl_selected = 2'd1; start_req = 1'b1; tick(); start_req = 1'b0;
    level_comp = 1'b1; tick(); level_comp = 1'b0;
    checks++;
    if (game_state !== 3'd3 || secs_left !== 4'd3 || lvl !== 2'd1) begin
      failures++;
      $display("FAIL win_entry got st=%0d secs=%0d lvl=%0d exp st=3 secs=3 lvl=1",
               game_state, secs_left, lvl);
    end
    sec_pulse(); sec_pulse(); sec_pulse();
    checks++;
    if (game_state !== 3'd1 || lvl !== 2'd2 || reset_lvl_N !== 1'b1) begin
      failures++;
      $display("FAIL win_next got st=%0d lvl=%0d rn=%0b exp st=1 lvl=2 rn=1",
               game_state, lvl, reset_lvl_N);
    end
    level_comp = 1'b1; tick(); level_comp = 1'b0;
    sec_pulse(); sec_pulse(); sec_pulse();
    checks++;
    if (game_state !== 3'd0 || lvl !== 2'd0) begin
      failures++;
      $display("FAIL win_campaign got st=%0d lvl=%0d exp st=0 lvl=0", game_state, lvl);
    end
  endtask

  task automatic test_clamp_and_midreset();
    lvl_selected = 2'd3; start_req = 1'b1; tick(); start_req = 1'b0;
    checks++;
    if (game_state !== 3'd1 || lvl !== 2'd2) begin
      failures++;
      $display("FAIL lvl_clamp got st=%0d lvl=%0d exp st=1 lvl=2", game_state, lvl);
    end
    bumpy_died = 1'b1; tick(); bumpy_died = 1'b0;
    sec_pulse(); sec_pulse(); sec_pulse();
    level_comp = 1'b1; tick(); level_comp = 1'b0;
    sec_pulse(); sec_pulse();
    checks++;
    if (game_state !== 3'd3 || secs_left !== 4'd1 || lives !== 3'd2) begin
      failures++;
      $display("FAIL win_pre_reset got st=%0d secs=%0d lives=%0d exp st=3 secs=1 lives=2",
               game_state, secs_left, lives);
    end
    resetN = 1'b0; tick(); resetN = 1'b1;
    checks++;
    if (game_state !== 3'd0 || lives !== 3'd3 || lvl !== 2'd0 || secs_left !== 4'd0 || reset_lvl_N !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got st=%0d lives=%0d lvl=%0d secs=%0d rn=%0b exp st=0 lives=3 lvl=0 secs=0 rn=0",
               game_state, lives, lvl, secs_left, reset_lvl_N);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_died_hold();
    test_died_and_level();
    test_win_progress();
    test_clamp_and_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_flow_sequencer.md
Name: game_flow_sequencer

Overview:
- Top-level game-flow controller for Bumpy.
- Sequences the menu, play, died, win and game-over screens from one_sec ticks.
- Owns the lives counter and level progression.
- Drives the level-reset strobe for the play datapath and the screen-select code for the display mux.

Parameters:
SCREEN_SEC, 3, duration in one_sec ticks of the DIED/WIN/OVER screens (2..15)
START_LIVES, 3, lives loaded on game start (1..7)
NUM_LEVELS, 3, number of playable levels (1..4)

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset, sampled on posedge clk
one_sec  in  1  one-clk-wide pulse once per second, synchronous to clk
start_req  in  1  menu confirm (level), rising edge used
lvl_selected  in  2  level chosen in menu
bumpy_died  in  1  player death (level), rising edge used
level_comp  in  1  level finished (level), rising edge used
game_state  out  3  0=MENU 1=PLAY 2=DIED 3=WIN 4=OVER
reset_lvl_N  out  1  active-low level-datapath reset
lvl  out  2  current level
lives  out  3  remaining lives
secs_left  out  4  seconds remaining on a timed screen

Behaviour:
- Single clock domain: every flop on posedge clk; resetN synchronous, active-low; one_sec used only as an enable, never as a clock.
- Reset values: state MENU, lvl=0, lives=START_LIVES, timer=0, edge-detect registers=0.
- Reset outputs: game_state=0, reset_lvl_N=0, secs_left=0.
- Edge events: evt_x = x & ~x_d, where x_d is a registered copy of x.
  - A level already high at reset release yields one event in the first cycle.
- reset_lvl_N = (state==PLAY), decoded from state with no extra delay.
  - It drops in the same cycle the FSM leaves PLAY.
  - It rises in the first cycle of PLAY, including re-entry from DIED or WIN.
- MENU:
  - On evt_start: lvl <= min(lvl_selected, NUM_LEVELS-1), lives <= START_LIVES, go to PLAY.
  - bumpy_died and level_comp are ignored.
- PLAY, priority order:
  - evt_died (highest priority): if lives==1, lives <= 0 and go to OVER; else lives <= lives-1 and go to DIED.
  - evt_level (only if no death this cycle): go to WIN.
  - evt_start: ignored.
- Timed states DIED, WIN, OVER:
  - timer is 4 bits, cleared in the cycle of entry into any state.
  - A one_sec pulse coincident with the entry cycle is not counted.
  - Each later one_sec pulse: if timer==SCREEN_SEC-1, exit and clear timer; else timer <= timer+1.
  - Exit therefore happens on the SCREEN_SEC-th counted tick.
  - Edge events other than reset are ignored in these states.
- Exits from timed states:
  - DIED -> PLAY; lvl and lives unchanged.
  - WIN: if lvl==NUM_LEVELS-1, go to MENU with lvl <= 0 (campaign complete); else lvl <= lvl+1 and go to PLAY.
  - OVER -> MENU; lvl <= 0, lives <= START_LIVES.
- secs_left = SCREEN_SEC - timer in DIED/WIN/OVER; 0 in MENU/PLAY.
- Encodings 5..7 of state are unreachable; if ever entered, next state is MENU.
- Reset mid-screen: the next clk edge with resetN=0 forces every reset value, regardless of state or timer.
- lives never underflows; lvl never exceeds NUM_LEVELS-1.

Test Plan:
- Reset held 2 cycles then released, no inputs -> game_state=0, reset_lvl_N=0, lives=3, lvl=0, secs_left=0 indefinitely.
- lvl_selected=2, start_req pulse -> next cycle game_state=1, lvl=2, lives=3, reset_lvl_N=1.
- In PLAY, bumpy_died held high 10 cycles -> one decrement only: lives=2, game_state=2, secs_left=3.
  - Then 3 one_sec pulses -> secs_left 2,1 then game_state=1; bumpy_died still high does not re-trigger.
- In PLAY with lives=1, bumpy_died and level_comp rise in the same cycle -> game_state=4, lives=0.
  - After 3 one_sec pulses -> game_state=0, lives=3, lvl=0.
- In PLAY with lvl=1, level_comp -> WIN, then 3 ticks -> PLAY with lvl=2.
  - level_comp again, then 3 ticks -> MENU with lvl=0.
- In WIN with secs_left=1, resetN low for 1 cycle -> next cycle game_state=0, lives=3, lvl=0, secs_left=0.
